// File: rtl/uart_rx_engine.sv
// rtl/uart_rx_engine.sv - UART receive deframer (start/data/parity/stop, status flags)
// Optional overflow flag built only when UART_RX_OVF_EN is defined.
module uart_rx_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    input  logic [18:0] k,
    input  logic        EIGHT,
    input  logic        PEN,
    input  logic        OHEL,
    input  logic        CLR,
    output logic [7:0]  UART_RDATA,
    output logic        RXRDY,
    output logic        PERR,
    output logic        FERR,
    output logic        OVF
);

    typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_t;

    state_t      state, state_nxt;
    logic        rx_meta, rxs;
    logic [18:0] k_count, target;
    logic        counting, btu;
    logic [3:0]  bcnt, n_bits;
    logic [9:0]  sr;
    logic [7:0]  data;
    logic        parity, stop, perr_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RX;
            rxs     <= rx_meta;
        end
    end

    // Half a bit time in START lands the first sample at the start-bit centre.
    // Compare with >= so a mid-frame k change can never run the counter past target.
    assign target   = (state == START) ? (k >> 1) : k;
    assign counting = (state == START) || (state == DATA);
    assign btu      = counting && (k_count >= target);
    assign n_bits   = 4'd8 + {3'b000, EIGHT} + {3'b000, PEN};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_count <= '0;
        end else if (counting && !btu) begin
            k_count <= k_count + 19'd1;
        end else begin
            k_count <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt <= '0;
            sr   <= '1;
        end else if (state == IDLE) begin
            bcnt <= '0;
        end else if (state == DATA && btu) begin
            bcnt <= bcnt + 4'd1;
            sr   <= {rxs, sr[9:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!rxs) state_nxt = START;
            START: if (btu) state_nxt = rxs ? IDLE : DATA;
            DATA:  if (btu && ((bcnt + 4'd1) >= n_bits)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bits enter at the MSB, so the stop bit always ends up in sr[9].
    always_comb begin
        parity = 1'b0;
        data   = 8'h00;
        stop   = sr[9];
        case ({EIGHT, PEN})
            2'b11: begin parity = sr[8]; data = sr[7:0]; end
            2'b10: data = sr[8:1];
            2'b01: begin parity = sr[8]; data = {1'b0, sr[7:1]}; end
            default: data = {1'b0, sr[8:2]};
        endcase
    end

    assign perr_nxt = PEN & ((^data ^ parity) != OHEL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            UART_RDATA <= 8'h00;
            RXRDY      <= 1'b0;
            PERR       <= 1'b0;
            FERR       <= 1'b0;
        end else if (state == DONE) begin
            UART_RDATA <= data;
            RXRDY      <= 1'b1;
            PERR       <= perr_nxt;
            FERR       <= ~stop;
        end else if (CLR) begin
            RXRDY      <= 1'b0;
            PERR       <= 1'b0;
            FERR       <= 1'b0;
        end
    end

`ifdef UART_RX_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            OVF <= 1'b0;
        end else if (state == DONE) begin
            if (RXRDY) OVF <= 1'b1;
        end else if (CLR) begin
            OVF <= 1'b0;
        end
    end
`else
    assign OVF = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_engine.sv
// tb/tb_uart_rx_engine.sv - table-driven and directed checks for uart_rx_engine
module tb_uart_rx_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX = 1'b1;
    logic [18:0] k_r = 19'd9;
    logic        EIGHT = 1'b1;
    logic        PEN = 1'b0;
    logic        OHEL = 1'b0;
    logic        CLR = 1'b0;
    logic [7:0]  UART_RDATA;
    logic        RXRDY, PERR, FERR, OVF;

    int checks = 0;
    int errors = 0;

`ifdef UART_RX_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    uart_rx_engine dut (
        .clk(clk), .rst(rst), .RX(RX), .k(k_r),
        .EIGHT(EIGHT), .PEN(PEN), .OHEL(OHEL), .CLR(CLR),
        .UART_RDATA(UART_RDATA), .RXRDY(RXRDY), .PERR(PERR),
        .FERR(FERR), .OVF(OVF)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       eight, pen, ohel;
        int         kval;
        logic [7:0] tx;
        logic       par, stp;
        logic [7:0] exp_data;
        logic       exp_perr, exp_ferr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) tick();
    endtask

    task automatic send_bit(input logic b);
        RX = b;
        repeat (int'(k_r) + 1) tick();
    endtask

    task automatic send_frame(input logic [7:0] tx, input logic par, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < (EIGHT ? 8 : 7); i++) send_bit(tx[i]);
        if (PEN) send_bit(par);
        send_bit(stp);
        RX = 1'b1;
    endtask

    task automatic clr_pulse();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] d,
                                 input logic rdy, input logic pe, input logic fe, input logic ov);
        check({tag, "_data"}, UART_RDATA, d);
        check({tag, "_rxrdy"}, {7'b0, RXRDY}, {7'b0, rdy});
        check({tag, "_perr"}, {7'b0, PERR}, {7'b0, pe});
        check({tag, "_ferr"}, {7'b0, FERR}, {7'b0, fe});
        check({tag, "_ovf"}, {7'b0, OVF}, {7'b0, ov});
    endtask

    initial begin
        vecs[0] = '{"8N1_A5",       1'b1, 1'b0, 1'b0,  9, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{"7E1_41_p0",    1'b0, 1'b1, 1'b0,  9, 8'h41, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0};
        vecs[2] = '{"7E1_41_p1",    1'b0, 1'b1, 1'b0,  9, 8'h41, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0};
        vecs[3] = '{"8O1_00_p0",    1'b1, 1'b1, 1'b1,  9, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{"8N1_stop0",    1'b1, 1'b0, 1'b0,  9, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[5] = '{"7N1_k4",       1'b0, 1'b0, 1'b0,  4, 8'hD5, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
        vecs[6] = '{"8E1_81_k15",   1'b1, 1'b1, 1'b0, 15, 8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
        vecs[7] = '{"7O1_k3_stop0", 1'b0, 1'b1, 1'b1,  3, 8'h03, 1'b1, 1'b0, 8'h03, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_outputs("in_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        idle(5);
        @(negedge clk);
        check_outputs("post_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        for (int v = 0; v < 8; v++) begin
            EIGHT = vecs[v].eight;
            PEN   = vecs[v].pen;
            OHEL  = vecs[v].ohel;
            k_r   = 19'(vecs[v].kval);
            idle(4);
            send_frame(vecs[v].tx, vecs[v].par, vecs[v].stp);
            idle(4);
            @(negedge clk);
            check_outputs(vecs[v].name, vecs[v].exp_data, 1'b1,
                          vecs[v].exp_perr, vecs[v].exp_ferr, 1'b0);
            tick();
            clr_pulse();
            @(negedge clk);
            check({vecs[v].name, "_clr_rxrdy"}, {7'b0, RXRDY}, 8'h00);
            check({vecs[v].name, "_clr_perr"}, {7'b0, PERR}, 8'h00);
            check({vecs[v].name, "_clr_ferr"}, {7'b0, FERR}, 8'h00);
            check({vecs[v].name, "_clr_data_kept"}, UART_RDATA, vecs[v].exp_data);
            tick();
            idle(3 * (vecs[v].kval + 1));
        end

        // False start: a 3-cycle low pulse must be rejected at the half-bit check.
        EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0; k_r = 19'd19;
        idle(4);
        RX = 1'b0;
        repeat (3) tick();
        idle(40);
        @(negedge clk);
        check_outputs("false_start", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Back-to-back frames without a read in between.
        k_r = 19'd9;
        idle(4);
        send_frame(8'h12, 1'b0, 1'b1);
        send_frame(8'h34, 1'b0, 1'b1);
        idle(4);
        @(negedge clk);
        check_outputs("b2b", 8'h34, 1'b1, 1'b0, 1'b0, OVF_EXP);
        tick();
        clr_pulse();
        @(negedge clk);
        check_outputs("b2b_clr", 8'h34, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle(20);

        // Read strobe landing exactly on the second frame's DONE cycle (98 cycles in, k=9, 8N1).
        send_frame(8'h12, 1'b0, 1'b1);
        fork
            send_frame(8'h34, 1'b0, 1'b1);
            begin
                repeat (98) tick();
                CLR = 1'b1;
                tick();
                CLR = 1'b0;
            end
        join
        idle(4);
        @(negedge clk);
        check_outputs("clr_on_done", 8'h34, 1'b1, 1'b0, 1'b0, OVF_EXP);
        tick();
        clr_pulse();
        idle(20);

        // Reset in the middle of data bit 4, with flags previously set.
        send_frame(8'hC3, 1'b0, 1'b0);
        idle(4);
        @(negedge clk);
        check_outputs("pre_rst", 8'hC3, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        idle(30);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        RX = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        check_outputs("async_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        idle(20);
        send_frame(8'h5A, 1'b0, 1'b1);
        idle(4);
        @(negedge clk);
        check_outputs("after_rst_5A", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
